swm_loopback_tester: RTL



---
 rtl/swm_loopback_pkg.sv | 46 ++++
 rtl/swm_lfsr52.sv | 23 ++
 rtl/swm_loopback_tester.sv | 122 ++++++++++++
 3 files changed

// File: rtl/swm_loopback_pkg.sv
// Shared definitions for the vertical-wire loopback tester: bus layout, FSM states,
// and the north-terminator fold model (each wire group is bit-reversed within itself).
package swm_loopback_pkg;

    localparam int BUS_W   = 52;
    localparam int N1_W    = 4;
    localparam int N2_W    = 8;
    localparam int N4_W    = 16;
    localparam int N1_OFF  = 0;
    localparam int N2_OFF  = N1_OFF + N1_W;
    localparam int N2B_OFF = N2_OFF + N2_W;
    localparam int N4_OFF  = N2B_OFF + N2_W;
    localparam int NN4_OFF = N4_OFF + N4_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Reversal within a group is its own inverse, so this maps in both directions.
    function automatic int return_to_nbeg_index(input int i);
        if (i < N2_OFF)       return 2*N1_OFF  + N1_W - 1 - i;
        else if (i < N2B_OFF) return 2*N2_OFF  + N2_W - 1 - i;
        else if (i < N4_OFF)  return 2*N2B_OFF + N2_W - 1 - i;
        else if (i < NN4_OFF) return 2*N4_OFF  + N4_W - 1 - i;
        else                  return 2*NN4_OFF + N4_W - 1 - i;
    endfunction

    function automatic logic [BUS_W-1:0] expected_return(input logic [BUS_W-1:0] n);
        logic [BUS_W-1:0] r;
        r = '0;
        for (int i = 0; i < BUS_W; i++) r[i] = n[return_to_nbeg_index(i)];
        return r;
    endfunction

    function automatic logic [BUS_W-1:0] map_to_nbeg(input logic [BUS_W-1:0] m);
        logic [BUS_W-1:0] r;
        r = '0;
        for (int i = 0; i < BUS_W; i++) r[return_to_nbeg_index(i)] = m[i];
        return r;
    endfunction

endpackage

// File: rtl/swm_lfsr52.sv
// 52-bit Fibonacci LFSR, x^52 + x^49 + 1, shifting left; a zero seed loads as 1.
module swm_lfsr52
    import swm_loopback_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [BUS_W-1:0] seed,
    output logic [BUS_W-1:0] state
);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= '0;
        end else if (load) begin
            state <= (seed == '0) ? {{(BUS_W-1){1'b0}}, 1'b1} : seed;
        end else if (advance) begin
            state <= {state[BUS_W-2:0], state[51] ^ state[48]};
        end
    end

endmodule

// File: rtl/swm_loopback_tester.sv
// BIST source/sink for a column's vertical wires: drives LFSR patterns north and checks the folded return.
// Optional per-wire sticky failure mask is built only when SWM_LOOPBACK_FAILMASK_EN is defined.
module swm_loopback_tester
    import swm_loopback_pkg::*;
#(
    parameter int               SETTLE_CYCLES = 4,
    parameter int               NUM_PATTERNS  = 256,
    parameter logic [BUS_W-1:0] LFSR_SEED     = 52'h1
) (
    input  logic             UserCLK,
    input  logic             Reset,
    input  logic             start,
    output logic [BUS_W-1:0] nbeg,
    input  logic [BUS_W-1:0] send,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [BUS_W-1:0] fail_mask
);

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [15:0] IDX_LAST    = 16'(NUM_PATTERNS - 1);

    state_t           state, next_state;
    logic [31:0]      settle_cnt;
    logic [15:0]      idx;
    logic [15:0]      err_next;
    logic [BUS_W-1:0] pattern;
    logic [BUS_W-1:0] mismatch;
    logic             lfsr_load, lfsr_adv, any_mismatch;

    swm_lfsr52 u_lfsr (
        .clock   (UserCLK),
        .reset   (Reset),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .seed    (LFSR_SEED),
        .state   (pattern)
    );

    assign mismatch     = send ^ expected_return(nbeg);
    assign any_mismatch = |mismatch;
    assign err_next     = (any_mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;

    // busy is a registered copy of the state, so it also gates start during the first DONE cycle.
    always_comb begin
        next_state = state;
        lfsr_load  = 1'b0;
        lfsr_adv   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start && !busy) begin
                    next_state = ST_DRIVE;
                    lfsr_load  = 1'b1;
                end
            end
            ST_DRIVE:  next_state = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SETTLE_LAST) next_state = ST_CHECK;
            ST_CHECK: begin
                lfsr_adv   = 1'b1;
                next_state = (idx == IDX_LAST) ? ST_DONE : ST_DRIVE;
            end
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state      <= ST_IDLE;
            nbeg       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            settle_cnt <= '0;
            idx        <= '0;
        end else begin
            state <= next_state;
            busy  <= (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_CHECK);
            done  <= (state == ST_DONE);
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (lfsr_load) begin
                        err_count <= '0;
                        idx       <= '0;
                    end
                end
                ST_DRIVE: begin
                    nbeg       <= pattern;
                    settle_cnt <= '0;
                end
                ST_SETTLE: settle_cnt <= settle_cnt + 32'd1;
                ST_CHECK: begin
                    err_count <= err_next;
                    if (next_state == ST_DONE) pass <= (err_next == 16'd0);
                    else                       idx  <= idx + 16'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef SWM_LOOPBACK_FAILMASK_EN
    logic [BUS_W-1:0] mask_q;

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            mask_q <= '0;
        end else if (lfsr_load) begin
            mask_q <= '0;
        end else if (state == ST_CHECK) begin
            mask_q <= mask_q | map_to_nbeg(mismatch);
        end
    end

    assign fail_mask = mask_q;
`else
    assign fail_mask = '0;
`endif

endmodule
